ultrasonic_ranger: RTL and testbench

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/ultrasonic_ranger.sv | 177 +++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic range finder controller.
// The block fires a trigger pulse, times the returning echo in microsecond
// ticks, and converts the echo width to centimetres. It then waits out the
// remainder of the trigger period before the next shot.
// Results (dist_cm, near, timeout) are registered and held between updates.
// valid is a single-cycle strobe that marks each update; there is no back-pressure.
module ultrasonic_ranger #(
    parameter int unsigned CLK_PER_US = 50,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned PERIOD_US  = 60000,
    parameter int unsigned TIMEOUT_US = 25000,
    parameter int unsigned US_PER_CM  = 58,
    parameter int unsigned MAX_CM     = 400,
    parameter int unsigned NEAR_CM    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       echo,
    output logic       trig,
    output logic [8:0] dist_cm,
    output logic       valid,
    output logic       near,
    output logic       timeout
);

    localparam int unsigned PERIOD_CYC = PERIOD_US * CLK_PER_US;
    // One common width, sized for the longest interval the block ever counts.
    localparam int unsigned CW = $clog2(PERIOD_CYC + 1);

    localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_PER_US - 1);
    localparam logic [CW-1:0] TRIG_LAST   = CW'(TRIG_US - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_US - 1);
    localparam logic [CW-1:0] CM_LAST     = CW'(US_PER_CM - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CYC - 1);
    localparam logic [8:0]    MAX_CM_V    = 9'(MAX_CM);
    localparam logic [8:0]    NEAR_CM_V   = 9'(NEAR_CM);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic          echo_m_q, echo_s_q, echo_p_q;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] us_q, us_d;
    logic [CW-1:0] cmdiv_q, cmdiv_d;
    logic [CW-1:0] period_q, period_d;
    logic [8:0]    cm_q, cm_d;
    logic          trig_q, trig_d;
    logic [8:0]    dist_q, dist_d;
    logic          valid_q, valid_d;
    logic          near_q, near_d;
    logic          timeout_q, timeout_d;

    logic       tick, echo_rise, echo_fall;
    logic       us_last, trig_done, period_done;
    logic       cm_step, meas_done, to_hit, state_chg, enter_trig;
    logic [8:0] cm_inc, cm_now;

    assign tick        = (div_q == DIV_LAST);
    assign echo_rise   = echo_s_q & ~echo_p_q;
    assign echo_fall   = ~echo_s_q & echo_p_q;
    assign us_last     = tick && (us_q == TO_LAST);
    assign trig_done   = tick && (us_q == TRIG_LAST);
    assign period_done = (period_q >= PERIOD_LAST);

    // cm_now includes a step landing in the current cycle, so a falling edge
    // seen on the last cycle of a whole centimetre still counts it.
    assign cm_step   = tick && (cmdiv_q == CM_LAST);
    assign cm_inc    = (cm_q >= MAX_CM_V) ? cm_q : cm_q + 9'd1;
    assign cm_now    = cm_step ? cm_inc : cm_q;
    assign meas_done = (state_q == S_MEASURE) && echo_fall;
    assign to_hit    = ((state_q == S_WAIT_ECHO) && !echo_rise && us_last) ||
                       ((state_q == S_MEASURE)   && !echo_fall && us_last);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (en) state_d = S_TRIG;
            S_TRIG:      if (trig_done) state_d = S_WAIT_ECHO;
            S_WAIT_ECHO: if (echo_rise) state_d = S_MEASURE;
                         else if (us_last) state_d = S_HOLDOFF;
            S_MEASURE:   if (echo_fall || us_last) state_d = S_HOLDOFF;
            S_HOLDOFF:   if (period_done) state_d = en ? S_TRIG : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Counter next values: tick divider and us counter restart on every state entry.
    always_comb begin
        state_chg  = (state_d != state_q);
        enter_trig = (state_d == S_TRIG) && (state_q != S_TRIG);
        div_d      = (state_chg || tick) ? '0 : div_q + 1'b1;
        us_d       = state_chg ? '0 : ((tick && (us_q != '1)) ? us_q + 1'b1 : us_q);
        period_d   = enter_trig ? '0 : (period_done ? period_q : period_q + 1'b1);
        cmdiv_d    = cmdiv_q;
        cm_d       = cm_q;
        if (state_chg) begin
            cmdiv_d = '0;
            cm_d    = '0;
        end else if (state_q == S_MEASURE) begin
            cm_d = cm_now;
            if (tick) cmdiv_d = cm_step ? '0 : cmdiv_q + 1'b1;
        end
    end

    // Output logic: trigger level and result update.
    always_comb begin
        trig_d    = (state_q == S_TRIG);
        valid_d   = meas_done | to_hit;
        dist_d    = dist_q;
        near_d    = near_q;
        timeout_d = timeout_q;
        if (meas_done) begin
            dist_d    = cm_now;
            near_d    = (cm_now < NEAR_CM_V);
            timeout_d = 1'b0;
        end else if (to_hit) begin
            dist_d    = MAX_CM_V;
            near_d    = 1'b0;
            timeout_d = 1'b1;
        end
    end

    // Echo synchronizer, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_m_q  <= 1'b0;
            echo_s_q  <= 1'b0;
            echo_p_q  <= 1'b0;
            div_q     <= '0;
            us_q      <= '0;
            cmdiv_q   <= '0;
            period_q  <= '0;
            cm_q      <= '0;
            trig_q    <= 1'b0;
            dist_q    <= '0;
            valid_q   <= 1'b0;
            near_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            echo_m_q  <= echo;
            echo_s_q  <= echo_m_q;
            echo_p_q  <= echo_s_q;
            div_q     <= div_d;
            us_q      <= us_d;
            cmdiv_q   <= cmdiv_d;
            period_q  <= period_d;
            cm_q      <= cm_d;
            trig_q    <= trig_d;
            dist_q    <= dist_d;
            valid_q   <= valid_d;
            near_q    <= near_d;
            timeout_q <= timeout_d;
        end
    end

    assign trig    = trig_q;
    assign dist_cm = dist_q;
    assign valid   = valid_q;
    assign near    = near_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger with a fast clock ratio and shortened period/timeout.
module tb_ultrasonic_ranger;

    localparam int CLK_PER_US = 2;
    localparam int TRIG_US    = 10;
    localparam int PERIOD_US  = 4000;
    localparam int TIMEOUT_US = 3000;
    localparam int US_PER_CM  = 58;
    localparam int MAX_CM     = 400;
    localparam int NEAR_CM    = 20;

    localparam int TRIG_CYC   = TRIG_US * CLK_PER_US;
    localparam int PERIOD_CYC = PERIOD_US * CLK_PER_US;
    localparam int TO_CYC     = TIMEOUT_US * CLK_PER_US;

    logic       clk, rst, en, echo;
    logic       trig, valid, near, timeout;
    logic [8:0] dist_cm;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int prev_rise = 0;
    bit have_prev = 0;

    typedef struct {
        int delay_us;
        int width_us;
        int trig_pulse;
        int drop_en_us;
        int exp_dist;
        int exp_near;
        int exp_to;
    } vec_t;

    vec_t vecs[5];

    ultrasonic_ranger #(
        .CLK_PER_US(CLK_PER_US), .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US),
        .TIMEOUT_US(TIMEOUT_US), .US_PER_CM(US_PER_CM), .MAX_CM(MAX_CM),
        .NEAR_CM(NEAR_CM)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo),
        .trig(trig), .dist_cm(dist_cm), .valid(valid), .near(near),
        .timeout(timeout)
    );

    // clock / cycle counter / valid counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (valid) valid_cnt <= valid_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_trig"}, int'(trig), 0);
        check({tag, "_dist"}, int'(dist_cm), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_near"}, int'(near), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
    endtask

    task automatic wait_trig_edge(input logic level, input int budget, output int at, output bit ok);
        logic prev;
        prev = trig;
        ok = 0;
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (trig == level && prev != level) begin
                ok = 1;
                at = cyc;
                break;
            end
            prev = trig;
        end
    endtask

    task automatic wait_valid(input int budget, output int at, output bit ok);
        ok = 0;
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (valid) begin
                ok = 1;
                at = cyc;
                break;
            end
        end
    endtask

    // One full measurement cycle: trigger, optional echo, result check.
    task automatic do_measure(input string tag, input vec_t v);
        int r, f, at, e0;
        bit ok;
        wait_trig_edge(1'b1, PERIOD_CYC + 50, r, ok);
        check({tag, "_trig_rise"}, int'(ok), 1);
        if (have_prev) check({tag, "_period"}, r - prev_rise, PERIOD_CYC);
        prev_rise = r;
        have_prev = 1;
        if (v.trig_pulse > 0) begin
            @(negedge clk) echo = 1'b1;
            repeat (v.trig_pulse) @(negedge clk);
            echo = 1'b0;
        end
        wait_trig_edge(1'b0, TRIG_CYC + 10, f, ok);
        check({tag, "_trig_width"}, f - r, TRIG_CYC);
        @(negedge clk);
        repeat (v.delay_us * CLK_PER_US) @(negedge clk);
        if (v.width_us > 0) begin
            echo = 1'b1;
            if (v.drop_en_us > 0) begin
                repeat (v.drop_en_us * CLK_PER_US) @(negedge clk);
                en = 1'b0;
                repeat ((v.width_us - v.drop_en_us) * CLK_PER_US) @(negedge clk);
            end else begin
                repeat (v.width_us * CLK_PER_US) @(negedge clk);
            end
            echo = 1'b0;
            e0 = cyc;
            wait_valid(4, at, ok);
            check_range({tag, "_valid_latency"}, ok ? at - e0 : 99, 1, 3);
        end else begin
            wait_valid(TO_CYC + 50, at, ok);
            check_range({tag, "_timeout_delay"}, ok ? at - f : -1, TO_CYC - 2, TO_CYC + 2);
        end
        check({tag, "_dist"}, int'(dist_cm), v.exp_dist);
        check({tag, "_near"}, int'(near), v.exp_near);
        check({tag, "_timeout"}, int'(timeout), v.exp_to);
        @(posedge clk); #1;
        check({tag, "_valid_one_cycle"}, int'(valid), 0);
    endtask

    initial begin
        int vc0, highs;
        vec_t v;
        // delay_us, width_us, trig_pulse, drop_en_us, exp_dist, exp_near, exp_to
        vecs[0] = '{100,  580, 0, 0,  10, 1, 0};
        vecs[1] = '{100, 1160, 0, 0,  20, 0, 0};
        vecs[2] = '{100, 1159, 0, 0,  19, 1, 0};
        vecs[3] = '{  0,    0, 0, 0, 400, 0, 1};
        vecs[4] = '{ 50,  580, 6, 0,  10, 1, 0};

        rst = 1'b0; en = 1'b0; echo = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_zero_outputs("reset");

        // First trigger on the second edge after release; async reset mid-trigger.
        @(negedge clk) begin rst = 1'b1; en = 1'b1; end
        @(posedge clk); #1;
        check("rel_edge1_trig", int'(trig), 0);
        @(posedge clk); #1;
        check("rel_edge2_trig", int'(trig), 1);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1 check("async_rst_trig", int'(trig), 0);
        repeat (2) @(negedge clk);
        check_zero_outputs("in_reset");
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            do_measure($sformatf("vec%0d", i), vecs[i]);
        end

        // Echo stuck high across the trigger: timeout, not a measurement.
        @(negedge clk) echo = 1'b1;
        v = '{0, 0, 0, 0, 400, 0, 1};
        do_measure("stuck", v);

        // Echo pulses during holdoff must not produce a result.
        @(negedge clk) echo = 1'b0;
        vc0 = valid_cnt;
        repeat (3) begin
            repeat (200) @(negedge clk);
            echo = 1'b1;
            repeat (100) @(negedge clk);
            echo = 1'b0;
        end
        // en dropped mid-measurement: result still reported, then idle.
        v = '{100, 2900, 0, 1000, 50, 0, 0};
        do_measure("en_drop", v);
        check("holdoff_pulses_no_valid", valid_cnt - vc0, 1);

        vc0 = valid_cnt;
        highs = 0;
        repeat (PERIOD_CYC + 100) begin
            @(posedge clk); #1;
            if (trig) highs++;
        end
        check("idle_no_trig", highs, 0);
        check("idle_no_valid", valid_cnt - vc0, 0);
        check("idle_dist_held", int'(dist_cm), 50);

        @(negedge clk) en = 1'b1;
        @(posedge clk); #1;
        check("reen_edge1_trig", int'(trig), 0);
        @(posedge clk); #1;
        check("reen_edge2_trig", int'(trig), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
